// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_pkg
//  Purpose  : Shared constants, state encoding and slot record for sprite eval
//  Revision : 1.0
// ============================================================================
package ppu_pkg;

  localparam logic [1:0] OAM_Y    = 2'd0;
  localparam logic [1:0] OAM_TILE = 2'd1;
  localparam logic [1:0] OAM_ATTR = 2'd2;
  localparam logic [1:0] OAM_X    = 2'd3;

  localparam int         ATTR_VFLIP = 7;
  localparam int         SPR_HEIGHT = 8;
  localparam int         MAX_SPR    = 8;
  localparam logic [7:0] EMPTY_XPOS = 8'hFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    EVAL_Y    = 3'd1,
    EVAL_COPY = 3'd2,
    FETCH_P0  = 3'd3,
    FETCH_P1  = 3'd4,
    LOAD      = 3'd5,
    DONE      = 3'd6
  } state_e;

  typedef struct packed {
    logic [2:0] row;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] xpos;
  } slot_t;

  // Vertical flip of a 3-bit row is its bitwise complement (7 - row).
  function automatic logic [2:0] eff_row(input slot_t s);
    return s.attr[ATTR_VFLIP] ? ~s.row : s.row;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppu_sprite_eval_if.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_sprite_eval_if
//  Purpose  : OAM / pattern memory and sprite-slot delivery bus of the engine
//  Revision : 1.0
// ============================================================================
interface ppu_sprite_eval_if;
  logic        start;
  logic [7:0]  scanline;
  logic        pattern_sel;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic [12:0] pat_addr;
  logic [7:0]  pat_data;
  logic        sprite_load;
  logic [2:0]  sprite_num;
  logic [7:0]  sprite_xpos;
  logic [7:0]  sprite_attr;
  logic [7:0]  sprite_line0;
  logic [7:0]  sprite_line1;
  logic        sprite0_on_line;
  logic        overflow;
  logic        busy;
  logic        done;

  modport master (
    input  start, scanline, pattern_sel, oam_data, pat_data,
    output oam_addr, pat_addr, sprite_load, sprite_num, sprite_xpos,
           sprite_attr, sprite_line0, sprite_line1, sprite0_on_line,
           overflow, busy, done
  );

  modport slave (
    output start, scanline, pattern_sel, oam_data, pat_data,
    input  oam_addr, pat_addr, sprite_load, sprite_num, sprite_xpos,
           sprite_attr, sprite_line0, sprite_line1, sprite0_on_line,
           overflow, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/ppu_sprite_slot_buf.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_sprite_slot_buf
//  Purpose  : Secondary-OAM register file, one field written per access
//  Revision : 1.0
// ============================================================================
module ppu_sprite_slot_buf
  import ppu_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  wire                       clk_100mhz,
  input  wire                       rst_n,
  input  wire                       i_clr,
  input  wire                       i_wr_en,
  input  wire [$clog2(DEPTH)-1:0]   i_wr_idx,
  input  wire [1:0]                 i_wr_field,
  input  wire [7:0]                 i_wr_data,
  input  wire [$clog2(DEPTH)-1:0]   i_rd_idx,
  output slot_t                     o_rd_slot
);

  slot_t r_mem [DEPTH];

  // Field select reuses the OAM byte offset; the Y slot holds the row.
  always_ff @(posedge clk_100mhz) begin
    if (!rst_n || i_clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_wr_en) begin
      case (i_wr_field)
        OAM_Y:    r_mem[i_wr_idx].row  <= i_wr_data[2:0];
        OAM_TILE: r_mem[i_wr_idx].tile <= i_wr_data;
        OAM_ATTR: r_mem[i_wr_idx].attr <= i_wr_data;
        default:  r_mem[i_wr_idx].xpos <= i_wr_data;
      endcase
    end
  end

  assign o_rd_slot = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/ppu_sprite_eval.sv
`default_nettype none
// ============================================================================
//  Module   : ppu_sprite_eval
//  Purpose  : Per-scanline sprite selection from OAM and pattern byte fetch
//  Revision : 1.0
// ============================================================================
module ppu_sprite_eval
  import ppu_pkg::*;
#(
  parameter int NUM_OAM    = 64,
  parameter int MAX_SPR    = 8,
  parameter int SPR_HEIGHT = 8
) (
  input  wire               clk_100mhz,
  input  wire               rst_n,
  ppu_sprite_eval_if.master bus
);

  localparam int                c_NW        = $clog2(NUM_OAM);
  localparam logic [7:0]        c_SPR_H     = 8'(SPR_HEIGHT);
  localparam logic [3:0]        c_MAX       = 4'(MAX_SPR);
  localparam logic [2:0]        c_LAST_SLOT = 3'(MAX_SPR - 1);
  localparam logic [c_NW-1:0]   c_LAST_N    = c_NW'(NUM_OAM - 1);

  state_e          r_state, w_state_nxt;
  logic            r_phase, w_phase_nxt;
  logic [c_NW-1:0] r_n, w_n_nxt;
  logic [1:0]      r_off, w_off_nxt;
  logic [3:0]      r_found, w_found_nxt;
  logic [2:0]      r_slot, w_slot_nxt;
  logic [7:0]      r_line0, w_line0_nxt;
  logic            r_s0, w_s0_nxt, r_ovf, w_ovf_nxt;
  logic [2:0]      r_num;
  logic [7:0]      r_xpos, r_attr, r_l0, r_l1;

  logic            w_clr, w_wr_en, w_goto_slot, w_ld_en;
  logic [7:0]      w_wr_data;
  logic [2:0]      w_ld_num;
  logic [7:0]      w_ld_xpos, w_ld_attr, w_ld_l0, w_ld_l1;
  logic [7:0]      w_row;
  logic            w_hit, w_last;
  slot_t           w_rd_slot;

  assign w_row  = bus.scanline - bus.oam_data;
  assign w_hit  = (w_row < c_SPR_H);
  assign w_last = (r_n == c_LAST_N);

  ppu_sprite_slot_buf #(.DEPTH(MAX_SPR)) u_slot_buf (
    .clk_100mhz (clk_100mhz),
    .rst_n      (rst_n),
    .i_clr      (w_clr),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (r_found[2:0]),
    .i_wr_field (r_off),
    .i_wr_data  (w_wr_data),
    .i_rd_idx   (r_slot),
    .o_rd_slot  (w_rd_slot)
  );

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_phase <= 1'b0;
      r_n     <= '0;
      r_off   <= OAM_Y;
      r_found <= '0;
      r_slot  <= '0;
      r_line0 <= '0;
      r_s0    <= 1'b0;
      r_ovf   <= 1'b0;
      r_num   <= '0;
      r_xpos  <= '0;
      r_attr  <= '0;
      r_l0    <= '0;
      r_l1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_n     <= w_n_nxt;
      r_off   <= w_off_nxt;
      r_found <= w_found_nxt;
      r_slot  <= w_slot_nxt;
      r_line0 <= w_line0_nxt;
      r_s0    <= w_s0_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_ld_en) begin
        r_num  <= w_ld_num;
        r_xpos <= w_ld_xpos;
        r_attr <= w_ld_attr;
        r_l0   <= w_ld_l0;
        r_l1   <= w_ld_l1;
      end
    end
  end

  // Each byte read is an address phase (r_phase=0) then a data phase; the
  // start cycle itself serves as the address phase of entry 0's Y byte.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_n_nxt     = r_n;
    w_off_nxt   = r_off;
    w_found_nxt = r_found;
    w_slot_nxt  = r_slot;
    w_line0_nxt = r_line0;
    w_s0_nxt    = r_s0;
    w_ovf_nxt   = r_ovf;
    w_clr       = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_data   = (r_off == OAM_Y) ? w_row : bus.oam_data;
    w_goto_slot = 1'b0;
    w_ld_en     = 1'b0;
    w_ld_num    = r_slot;
    w_ld_xpos   = w_rd_slot.xpos;
    w_ld_attr   = w_rd_slot.attr;
    w_ld_l0     = r_line0;
    w_ld_l1     = bus.pat_data;

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_clr       = 1'b1;
          w_found_nxt = '0;
          w_s0_nxt    = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_n_nxt     = '0;
          w_off_nxt   = OAM_Y;
          w_phase_nxt = 1'b1;
          w_state_nxt = EVAL_Y;
        end
      end
      EVAL_Y: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          if (w_hit && (r_found == c_MAX)) begin
            w_ovf_nxt   = 1'b1;
            w_goto_slot = 1'b1;
            w_slot_nxt  = '0;
          end else if (w_hit) begin
            w_wr_en     = 1'b1;
            w_off_nxt   = OAM_TILE;
            w_state_nxt = EVAL_COPY;
            if (r_n == '0) w_s0_nxt = 1'b1;
          end else if (w_last) begin
            w_goto_slot = 1'b1;
            w_slot_nxt  = '0;
          end else begin
            w_n_nxt = r_n + c_NW'(1);
          end
        end
      end
      EVAL_COPY: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          w_wr_en = 1'b1;
          if (r_off == OAM_X) begin
            w_found_nxt = r_found + 4'd1;
            w_off_nxt   = OAM_Y;
            if (w_last) begin
              w_goto_slot = 1'b1;
              w_slot_nxt  = '0;
            end else begin
              w_n_nxt     = r_n + c_NW'(1);
              w_state_nxt = EVAL_Y;
            end
          end else begin
            w_off_nxt = r_off + 2'd1;
          end
        end
      end
      FETCH_P0: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          w_line0_nxt = bus.pat_data;
          w_state_nxt = FETCH_P1;
        end
      end
      FETCH_P1: begin
        w_phase_nxt = ~r_phase;
        if (r_phase) begin
          w_ld_en     = 1'b1;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (r_slot == c_LAST_SLOT) begin
          w_state_nxt = DONE;
        end else begin
          w_goto_slot = 1'b1;
          w_slot_nxt  = r_slot + 3'd1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    // Empty slots skip the fetch and load blank data to flush stale sprites.
    if (w_goto_slot) begin
      w_phase_nxt = 1'b0;
      if ({1'b0, w_slot_nxt} < w_found_nxt) begin
        w_state_nxt = FETCH_P0;
      end else begin
        w_state_nxt = LOAD;
        w_ld_en     = 1'b1;
        w_ld_num    = w_slot_nxt;
        w_ld_xpos   = EMPTY_XPOS;
        w_ld_attr   = 8'h00;
        w_ld_l0     = 8'h00;
        w_ld_l1     = 8'h00;
      end
    end
  end

  assign bus.oam_addr = ((r_state == EVAL_Y) || (r_state == EVAL_COPY)) ?
                        8'({r_n, r_off}) : 8'h00;
  assign bus.pat_addr = ((r_state == FETCH_P0) || (r_state == FETCH_P1)) ?
                        {bus.pattern_sel, w_rd_slot.tile, (r_state == FETCH_P1),
                         eff_row(w_rd_slot)} : 13'h0000;

  assign bus.sprite_load     = (r_state == LOAD);
  assign bus.sprite_num      = r_num;
  assign bus.sprite_xpos     = r_xpos;
  assign bus.sprite_attr     = r_attr;
  assign bus.sprite_line0    = r_l0;
  assign bus.sprite_line1    = r_l1;
  assign bus.sprite0_on_line = r_s0;
  assign bus.overflow        = r_ovf;
  assign bus.busy            = (r_state != IDLE);
  assign bus.done            = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/ppu_sprite_eval.md
# ppu_sprite_eval

Per-scanline sprite evaluation and pattern fetch engine for the PPU. During horizontal blank it scans the 64-entry OAM and selects up to 8 sprites that cover the next scanline. It then reads their two pattern-plane bytes from the pattern table. It delivers all 8 slots to the scanline generator through the `sprite_load` / `sprite_num` / `sprite_xpos` / `sprite_attr` / `sprite_line0` / `sprite_line1` bus.

## Interface
Parameters:
- `NUM_OAM`, 64, number of OAM entries (4 bytes each)
- `MAX_SPR`, 8, sprite slots per line
- `SPR_HEIGHT`, 8, sprite height in rows

Ports:
- `clk_100mhz` in 1: the single clock
- `rst_n` in 1: synchronous, active-low reset
- `start` in 1: one-cycle pulse at start of hblank
- `scanline` in 8: line being prepared (next visible line)
- `pattern_sel` in 1: sprite pattern table select
- `oam_addr` out 8: OAM byte address
- `oam_data` in 8: OAM read data, valid 1 cycle after `oam_addr`
- `pat_addr` out 13: pattern table address = {`pattern_sel`, tile[7:0], plane, row[2:0]}
- `pat_data` in 8: pattern read data, valid 1 cycle after `pat_addr`
- `sprite_load` out 1: slot load strobe
- `sprite_num` out 3: slot index
- `sprite_xpos` out 8: slot X
- `sprite_attr` out 8: slot attribute, passed through unmodified
- `sprite_line0` out 8: pattern plane 0
- `sprite_line1` out 8: pattern plane 1
- `sprite0_on_line` out 1: OAM entry 0 is among the selected sprites
- `overflow` out 1: more than `MAX_SPR` sprites hit this line
- `busy` out 1: evaluation/fetch in progress
- `done` out 1: one-cycle pulse when all slots have been loaded

## Operation
- OAM entry n occupies bytes 4n+0 (Y), 4n+1 (tile), 4n+2 (attr), 4n+3 (X).
- States: IDLE, EVAL_Y, EVAL_COPY, FETCH_P0, FETCH_P1, LOAD, DONE.
- IDLE: on `start`, clear the slot buffer, clear the found count, clear `sprite0_on_line` and `overflow`, then go to EVAL_Y with n=0. `start` is ignored while `busy`=1.
- EVAL_Y: row = `scanline` − Y, computed as an 8-bit unsigned wrap. The sprite hits if row < `SPR_HEIGHT`.
  - Hit with found < 8: go to EVAL_COPY. Store row, tile, attr and X into slot[found], then increment found. If n=0, set `sprite0_on_line`.
  - Hit with found = 8: set `overflow` and end evaluation.
  - Miss: n++.
  - Evaluation ends after n = `NUM_OAM`−1.
- FETCH, for slot s = 0..7 in order:
  - Effective row = attr[7] (vflip) ? 7−row : row.
  - FETCH_P0 reads plane 0 (plane bit 0). FETCH_P1 reads plane 1 (plane bit 1).
  - LOAD then pulses `sprite_load` with `sprite_num`=s.
- Empty slots (s ≥ found) are still loaded, with no pattern reads: line0 = line1 = 0x00, attr = 0x00, xpos = 0xFF. This clears any stale sprite downstream.
- Horizontal flip is not applied here; attr goes downstream unchanged.
- After slot 7 is loaded, pulse `done` for one cycle and return to IDLE.
- Reset is applied synchronously at any time, including mid-operation. All outputs, `oam_addr`, `pat_addr`, flags and state return to 0 / IDLE.

## Timing
- Every OAM or pattern byte read takes 2 cycles: address is driven in cycle k, data is captured at the end of cycle k+1.
- Per-entry evaluation cost:
  - Miss: 2 cycles.
  - Hit: 8 cycles (Y, tile, attr, X).
- Fetch cost per slot:
  - Filled slot: 4 read cycles plus 1 LOAD cycle = 5 cycles.
  - Empty slot: LOAD only = 1 cycle.
- Worst case, from `start` to `done`, is 8·8 + 56·2 + 8·5 + 1 = 217 cycles. This fits within hblank (640 cycles at 100 MHz).
- During LOAD, `sprite_load` and the slot data are valid for exactly one cycle. Outside LOAD, `sprite_load`=0 and the data outputs hold their last value.
- `busy` is high from the cycle after `start` through the `done` cycle.
- `sprite0_on_line` and `overflow` are stable from `done` until the next `start`.

## Structure
- Shared package `ppu_pkg` holds:
  - OAM byte offsets (`OAM_Y`, `OAM_TILE`, `OAM_ATTR`, `OAM_X`)
  - `ATTR_VFLIP`=7
  - `SPR_HEIGHT`, `MAX_SPR`
  - the state enum
  - `EMPTY_XPOS`=0xFF
- Sub-module `ppu_sprite_slot_buf`: 8-entry secondary-OAM register file (row 3, tile 8, attr 8, X 8) with clear, write port and read port.

## Test plan
1. OAM all Y=0xF0, `scanline`=0x10 → 8 LOADs, all with line0=line1=0, xpos=0xFF; `overflow`=0; `done` at cycle 136.
2. Entry 0: Y=0x0E, tile=0x05, X=0x20, attr=0x00, `pattern_sel`=1, `scanline`=0x10 → row 2; reads at `pat_addr` 0x1052 and 0x105A; slot 0 loaded with xpos 0x20; `sprite0_on_line`=1.
3. Same as scenario 2 with attr=0x80 (vflip) → reads at 0x1055 and 0x105D; attr 0x80 passed through unchanged.
4. Ten sprites hit the line → slots 0–7 get entries in OAM order; `overflow`=1.
5. `start` pulsed again mid-fetch → ignored, the sequence completes unchanged.
6. `rst_n`=0 mid-fetch → next cycle IDLE with all outputs 0; `start` then runs a clean full sequence.
